// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS MEM stage: access sizes, exception codes and FSM states.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] EXC_NONE       = 2'd0;
  localparam logic [1:0] EXC_MISALIGNED = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL    = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StMerge
  } mem_state_e;

endpackage

// File: rtl/mips_mem_lane.sv
// Byte/halfword lane steering: extract-and-extend for loads, lane merge for sub-word stores.
module mips_mem_lane
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  always_comb begin
    shamt = 5'd0;
    // Big-endian puts offset 0 in the top byte, so the lane index is inverted.
    case (size_i)
      SZ_BYTE: shamt = BIG_ENDIAN ? {~offset_i, 3'b000} : {offset_i, 3'b000};
      SZ_HALF: shamt = BIG_ENDIAN ? {~offset_i[1], 4'b0000} : {offset_i[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
  end

  assign shifted = rdata_i >> shamt;

  always_comb begin
    load_data_o = rdata_i;
    mask        = 32'hFFFF_FFFF;
    ins         = {16'h0000, store_data_i};
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
        mask        = 32'h0000_00FF << shamt;
        ins         = {24'h00_0000, store_data_i[7:0]} << shamt;
      end
      SZ_HALF: begin
        load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        mask        = 32'h0000_FFFF << shamt;
        ins         = {16'h0000, store_data_i} << shamt;
      end
      default: ;
    endcase
  end

  assign merged_o = (rdata_i & ~mask) | (ins & mask);

endmodule

// File: rtl/mips_mem_stage.sv
// MIPS MEM stage: drives a word-only data memory, handles sub-word loads/stores (RMW) and
// registers the write-back result.
module mips_mem_stage
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  input  logic [31:0] mem_read_data,
  output logic        out_valid,
  output logic        out_reg_write,
  output logic [4:0]  out_rd,
  output logic [31:0] out_wb_data,
  output logic [1:0]  out_exc
);

  mem_state_e  state_q, state_d;
  logic        ld_q, ld_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] sdata_q, sdata_d;
  logic        rw_q, rw_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;

  logic        ovalid_q, ovalid_d;
  logic        orw_q, orw_d;
  logic [4:0]  ord_q, ord_d;
  logic [31:0] owb_q, owb_d;
  logic [1:0]  oexc_q, oexc_d;

  logic        is_mem, illegal, misaligned;
  logic [31:0] load_data, merged;

  mips_mem_lane #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .offset_i    (off_q),
    .rdata_i     (mem_read_data),
    .store_data_i(sdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  assign is_mem     = in_is_load | in_is_store;
  assign illegal    = (in_is_load & in_is_store) | (is_mem & (in_size == 2'd3));
  assign misaligned = is_mem & (((in_size == SZ_HALF) & in_addr[0]) |
                                ((in_size == SZ_WORD) & (in_addr[1:0] != 2'b00)));

  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    sdata_d  = sdata_q;
    rw_d     = rw_q;
    rd_d     = rd_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    ovalid_d = 1'b0;
    orw_d    = orw_q;
    ord_d    = ord_q;
    owb_d    = owb_q;
    oexc_d   = oexc_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (illegal || misaligned) begin
            ovalid_d = 1'b1;
            oexc_d   = illegal ? EXC_ILLEGAL : EXC_MISALIGNED;
            orw_d    = 1'b0;
            ord_d    = in_rd;
          end else if (!is_mem) begin
            ovalid_d = 1'b1;
            oexc_d   = EXC_NONE;
            orw_d    = in_reg_write;
            ord_d    = in_rd;
            owb_d    = in_alu_result;
          end else begin
            ld_d    = in_is_load;
            size_d  = in_size;
            uns_d   = in_unsigned;
            off_d   = in_addr[1:0];
            sdata_d = in_store_data[15:0];
            rw_d    = in_reg_write;
            rd_d    = in_rd;
            maddr_d = {in_addr[31:2], 2'b00};
            // Sub-word stores read the old word first; only word stores write directly.
            if (in_is_load || in_size != SZ_WORD) begin
              mrd_d = 1'b1;
            end else begin
              mwr_d    = 1'b1;
              mwdata_d = in_store_data;
            end
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (ld_q) begin
          ovalid_d = 1'b1;
          oexc_d   = EXC_NONE;
          orw_d    = rw_q;
          ord_d    = rd_q;
          owb_d    = load_data;
          state_d  = StIdle;
        end else if (size_q == SZ_WORD) begin
          ovalid_d = 1'b1;
          oexc_d   = EXC_NONE;
          orw_d    = 1'b0;
          ord_d    = rd_q;
          state_d  = StIdle;
        end else begin
          mwr_d    = 1'b1;
          mwdata_d = merged;
          state_d  = StMerge;
        end
      end
      StMerge: begin
        ovalid_d = 1'b1;
        oexc_d   = EXC_NONE;
        orw_d    = 1'b0;
        ord_d    = rd_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      ld_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      off_q    <= 2'b00;
      sdata_q  <= 16'h0000;
      rw_q     <= 1'b0;
      rd_q     <= 5'd0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      ovalid_q <= 1'b0;
      orw_q    <= 1'b0;
      ord_q    <= 5'd0;
      owb_q    <= 32'h0;
      oexc_q   <= EXC_NONE;
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      sdata_q  <= sdata_d;
      rw_q     <= rw_d;
      rd_q     <= rd_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      ovalid_q <= ovalid_d;
      orw_q    <= orw_d;
      ord_q    <= ord_d;
      owb_q    <= owb_d;
      oexc_q   <= oexc_d;
    end
  end

  assign in_ready       = (state_q == StIdle);
  assign mem_address    = maddr_q;
  assign mem_write_data = mwdata_q;
  assign sig_mem_read   = mrd_q;
  assign sig_mem_write  = mwr_q;
  assign out_valid      = ovalid_q;
  assign out_reg_write  = orw_q;
  assign out_rd         = ord_q;
  assign out_wb_data    = owb_q;
  assign out_exc        = oexc_q;

endmodule

// File: tb/tb_mips_mem_stage.sv
// Directed bench for mips_mem_stage with a small word memory model behind the port.
module tb_mips_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_is_load, in_is_store, in_unsigned, in_reg_write;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_store_data, in_alu_result;
  logic [4:0]  in_rd;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        sig_mem_read, sig_mem_write;
  logic        out_valid, out_reg_write;
  logic [4:0]  out_rd;
  logic [31:0] out_wb_data;
  logic [1:0]  out_exc;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int w0, r0;

  logic [31:0] mem [0:15];

  always #5 clock = ~clock;

  mips_mem_stage #(.BIG_ENDIAN(1'b1)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_alu_result (in_alu_result),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .sig_mem_read  (sig_mem_read),
    .sig_mem_write (sig_mem_write),
    .mem_read_data (mem_read_data),
    .out_valid     (out_valid),
    .out_reg_write (out_reg_write),
    .out_rd        (out_rd),
    .out_wb_data   (out_wb_data),
    .out_exc       (out_exc)
  );

  assign mem_read_data = mem[mem_address[5:2]];

  always @(posedge clock) begin
    if (sig_mem_write) mem[mem_address[5:2]] <= mem_write_data;
    if (sig_mem_write) wr_cnt <= wr_cnt + 1;
    if (sig_mem_read)  rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic rw,
                       input logic [4:0] rd, input logic [31:0] alu);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_is_store   = st;
    in_size       = sz;
    in_unsigned   = uns;
    in_addr       = addr;
    in_store_data = sdata;
    in_reg_write  = rw;
    in_rd         = rd;
    in_alu_result = alu;
  endtask

  task automatic store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d);
    drive(1'b0, 1'b1, sz, 1'b0, addr, d, 1'b0, 5'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    if (sz != 2'd2) tick();
    tick();
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                      input logic uns, input logic [4:0] rd, input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, uns, addr, 32'h0, 1'b1, rd, 32'h0);
    tick();
    in_valid = 1'b0;
    check({tag, "_rstrobe"}, {31'b0, sig_mem_read}, 32'd1);
    tick();
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, out_wb_data, exp);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    in_valid = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_strobes", {30'b0, sig_mem_read, sig_mem_write}, 32'd0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wdata", mem_write_data, 32'h0);
    check("rst_out", {24'b0, out_valid, out_reg_write, out_exc, 4'b0}, 32'd0);
    check("rst_rd", {27'b0, out_rd}, 32'd0);
    check("rst_wb", out_wb_data, 32'h0);
    reset = 1'b0;
    tick();

    // 1: sw then lw
    w0 = wr_cnt;
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'd4, 32'd12, 1'b0, 5'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("sw_wstrobe", {30'b0, sig_mem_write, sig_mem_read}, 32'd2);
    check("sw_addr", mem_address, 32'd4);
    check("sw_wdata", mem_write_data, 32'd12);
    check("sw_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("sw_done", {29'b0, out_valid, out_reg_write, sig_mem_write}, 32'd4);
    check("sw_count", wr_cnt - w0, 32'd1);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'd4, 32'h0, 1'b1, 5'd8, 32'h0);
    tick();
    in_valid = 1'b0;
    check("lw_addr", mem_address, 32'd4);
    check("lw_novalid", {31'b0, out_valid}, 32'd0);
    tick();
    check("lw_out", {25'b0, out_valid, out_reg_write, out_exc, 3'b0}, 32'h60);
    check("lw_rd", {27'b0, out_rd}, 32'd8);
    check("lw_data", out_wb_data, 32'd12);

    // 2: sub-word loads, big-endian
    store(32'd8, 2'd2, 32'h80FF7F01);
    load("lb", 32'd8, 2'd0, 1'b0, 5'd1, 32'hFFFFFF80);
    load("lbu", 32'd8, 2'd0, 1'b1, 5'd1, 32'h00000080);
    load("lh", 32'd10, 2'd1, 1'b0, 5'd1, 32'h00007F01);
    load("lhu", 32'd8, 2'd1, 1'b1, 5'd1, 32'h000080FF);
    load("lb3", 32'd11, 2'd0, 1'b0, 5'd1, 32'h00000001);

    // 3: sb as read-modify-write; upper store-data bits must be ignored
    store(32'd12, 2'd2, 32'h11223344);
    r0 = rd_cnt;
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'd13, 32'h123456AB, 1'b0, 5'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("sb_rd_phase", {29'b0, in_ready, sig_mem_read, sig_mem_write}, 32'd2);
    check("sb_addr", mem_address, 32'd12);
    tick();
    check("sb_wr_phase", {29'b0, in_ready, sig_mem_read, sig_mem_write}, 32'd1);
    check("sb_merged", mem_write_data, 32'h11AB3344);
    tick();
    check("sb_done", {29'b0, in_ready, out_valid, out_reg_write}, 32'd6);
    check("sb_reads", rd_cnt - r0, 32'd1);
    load("sb_lw", 32'd12, 2'd2, 1'b0, 5'd2, 32'h11AB3344);
    store(32'd14, 2'd1, 32'hFFFFBEEF);
    load("sh_lw", 32'd12, 2'd2, 1'b0, 5'd2, 32'h11ABBEEF);
    load("sh_lh", 32'd14, 2'd1, 1'b0, 5'd2, 32'hFFFFBEEF);

    // 4: exceptions issue no strobes
    w0 = wr_cnt;
    r0 = rd_cnt;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'd6, 32'h0, 1'b1, 5'd5, 32'h0);
    tick();
    check("mis_out", {28'b0, out_valid, out_reg_write, out_exc}, 32'h9);
    check("mis_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'd0, 32'h0, 1'b1, 5'd5, 32'h0);
    tick();
    check("ill_ldst", {28'b0, out_valid, out_reg_write, out_exc}, 32'hA);
    drive(1'b1, 1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 1'b1, 5'd5, 32'h0);
    tick();
    in_valid = 1'b0;
    check("ill_size", {28'b0, out_valid, out_reg_write, out_exc}, 32'hA);
    tick();
    check("exc_pulse", {31'b0, out_valid}, 32'd0);
    check("exc_nostrobe", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);

    // 5: back-to-back pass-through
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h0, 1'b1, 5'd3, 32'd955);
    tick();
    check("pt1_out", {28'b0, out_valid, out_reg_write, out_exc}, 32'hC);
    check("pt1_data", out_wb_data, 32'd955);
    check("pt1_rd", {26'b0, in_ready, out_rd}, 32'h23);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h0, 1'b0, 5'd4, 32'd956);
    tick();
    in_valid = 1'b0;
    check("pt2_out", {29'b0, out_valid, out_reg_write, in_ready}, 32'h5);
    check("pt2_data", out_wb_data, 32'd956);
    tick();
    check("pt_hold", {out_valid, out_wb_data[30:0]}, 32'd956);

    // 6: reset sampled at the edge that would enter MERGE of an sh
    w0 = wr_cnt;
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'd12, 32'h00005555, 1'b0, 5'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstm_strobes", {29'b0, in_ready, sig_mem_read, sig_mem_write}, 32'd4);
    check("rstm_addr", mem_address, 32'h0);
    check("rstm_out", {out_valid, out_wb_data[30:0]}, 32'd0);
    tick();
    check("rstm_idle", {30'b0, in_ready, sig_mem_write}, 32'd2);
    check("rstm_nowrite", wr_cnt - w0, 32'd0);
    load("rstm_mem", 32'd12, 2'd2, 1'b0, 5'd2, 32'h11ABBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mem_stage.md
Name: mips_mem_stage

Overview:
- MEM pipeline stage sitting between the EX/MEM boundary and mips_data_mem.
- Accepts one load, store or pass-through op at a time and drives the word-only data-memory port (address, write data, read strobe, write strobe).
- Performs byte and halfword extraction, with sign or zero extension, on loads.
- Implements byte and halfword stores as read-modify-write, since the memory only writes whole words.
- Registers the write-back result for the WB stage.

Parameters:
- BIG_ENDIAN, 1: byte lane order; 1 = byte offset 0 maps to bits 31:24; 0 = offset 0 maps to bits 7:0.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX presents an op.
- in_ready  out  1  stage can accept; transfer occurs when in_valid & in_ready at a clock edge.
- in_is_load  in  1  op is a load.
- in_is_store  in  1  op is a store.
- in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- in_unsigned  in  1  zero-extend load (lbu/lhu).
- in_addr  in  32  effective byte address (ALU result).
- in_store_data  in  32  rt value; low bits used for sub-word stores.
- in_reg_write  in  1  op writes rd.
- in_rd  in  5  destination register.
- in_alu_result  in  32  write-back value for non-memory ops.
- mem_address  out  32  word-aligned address to mips_data_mem.
- mem_write_data  out  32  word to write.
- sig_mem_read  out  1  read strobe.
- sig_mem_write  out  1  write strobe.
- mem_read_data  in  32  combinational read data from mips_data_mem.
- out_valid  out  1  one-cycle pulse: WB fields valid.
- out_reg_write  out  1  WB writes register.
- out_rd  out  5  WB destination.
- out_wb_data  out  32  loaded or pass-through value.
- out_exc  out  2  0 = none, 1 = misaligned, 2 = illegal op.

Behaviour:
- Reset values: state IDLE; in_ready 1; sig_mem_read 0; sig_mem_write 0; mem_address 0; mem_write_data 0; out_valid 0; out_reg_write 0; out_rd 0; out_wb_data 0; out_exc 0.
- All memory-side outputs are registered. Strobes are high for exactly one cycle each, with address and data stable that whole cycle.
- States:
  - IDLE: in_ready = 1.
  - ACCESS: in_ready = 0.
  - MERGE: in_ready = 0.
- IDLE, accepted op, classified in priority order:
  - Illegal (load & store both set, or size == 3 with load or store): no memory access; next cycle out_valid = 1, out_exc = 2, out_reg_write = 0; stay IDLE.
  - Misaligned (half with addr[0] = 1, or word with addr[1:0] != 0): next cycle out_valid = 1, out_exc = 1, out_reg_write = 0; stay IDLE.
  - Neither load nor store: next cycle out_valid = 1, out_wb_data = in_alu_result, with out_reg_write and out_rd passed through; stay IDLE.
  - Load, word store, or sub-word store: latch op fields; go ACCESS.
- ACCESS, load: sig_mem_read = 1 at addr & ~3. mem_read_data is sampled at the end of the cycle, then the lane is selected and extended. Next cycle out_valid = 1. Return to IDLE. Latency from accept to out_valid is 2 cycles.
- ACCESS, word store: sig_mem_write = 1, mem_write_data = store data; go IDLE. Next cycle out_valid = 1, out_reg_write = 0.
- ACCESS, sub-word store: sig_mem_read = 1; capture the old word; go MERGE.
- MERGE: sig_mem_write = 1 with the merged word. Only the addressed byte or half is replaced, using store_data[7:0] or [15:0]. Next cycle out_valid = 1, out_reg_write = 0; go IDLE. Accept to out_valid is 3 cycles.
- Throughput:
  - Pass-through and exception ops: 1 per cycle.
  - Loads and word stores: 1 per 2 cycles.
  - Sub-word stores: 1 per 3 cycles.
- Sign extension replicates bit 7 (byte) or bit 15 (half) when in_unsigned = 0; zeros otherwise. in_unsigned is ignored for word ops and stores.
- out_valid is a single-cycle pulse. When out_valid = 0, the out_* fields hold their last values; WB must qualify them with out_valid.
- Reset asserted in any state: next cycle is IDLE with all reset values. An in-flight op is dropped; no write strobe issues after the reset edge, even if reset arrives in MERGE.
- in_valid is ignored while in_ready = 0; EX must hold its op.

Decomposition:
- Shared package mips_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), out_exc codes (EXC_NONE, EXC_MISALIGNED, EXC_ILLEGAL), and state encodings.
- One natural sub-module, mips_mem_lane, purely combinational:
  - byte/half lane extract and extend for loads;
  - lane merge for stores;
  - BIG_ENDIAN-aware.

Test Plan:
1. sw addr 4, data 12, then lw addr 4, rd 8 → one sig_mem_write cycle at mem_address 4 with 12; later out_valid with out_wb_data 12, out_rd 8, out_exc 0.
2. Memory word 0x80FF7F01 at addr 8, BIG_ENDIAN = 1:
   - lb addr 8 → 0xFFFFFF80.
   - lbu addr 8 → 0x00000080.
   - lh addr 10 → 0x00007F01.
   - lhu addr 8 → 0x000080FF.
3. Word 0x11223344 at addr 12; sb addr 13, data 0xAB → read strobe, then write strobe with 0x11AB3344; in_ready low 2 cycles; subsequent lw addr 12 returns 0x11AB3344.
4. lw addr 6 → out_exc 1, out_reg_write 0, no strobes. Then load & store both set → out_exc 2, no strobes.
5. Pass-through op with alu 955, rd 3 → out_valid the next cycle with out_wb_data 955 and out_reg_write 1; back-to-back pass-throughs accepted every cycle.
6. Reset asserted during MERGE of sh → no write strobe follows; memory word unchanged; all outputs at reset values; in_ready 1 on the next cycle.
